bus_router_n: RTL

- Parametrised 1-master to NUM_SLAVES-slave router for the team's req/ack/cmd/addr/wdata/rdata bus.
- Successor to the fixed two-way master mux.
- Selects the slave by address bits, tracks one outstanding transaction in an FSM, and returns rdata/ack to the master.
- Adds an error response for unmapped addresses and for slaves that do not respond within TIMEOUT cycles.

---
 rtl/bus_pkg.sv | 22 ++
 rtl/bus_watchdog.sv | 45 ++++
 rtl/bus_router_n.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the req/ack bus router.
//   bus_rt_state_t : router FSM states (IDLE, BUSY, ERR)
//   CMD_READ/WRITE : encoding of the cmd bit
//   sel_width()    : width of the slave-select address field
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } bus_rt_state_t;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  // A single-slave router still decodes one select bit so that address
  // values with that bit set are reported as unmapped.
  function automatic int sel_width(input int num_slaves);
    return (num_slaves <= 1) ? 1 : $clog2(num_slaves);
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Transaction watchdog for the bus router.
// Ports:
//   clk, rst : clock, asynchronous active-low reset
//   clear    : reload the counter (held while the router is not BUSY)
//   enable   : count one BUSY cycle
//   expire   : high in the TIMEOUT-th consecutive enabled cycle
// TIMEOUT = 0 removes the counter and ties expire low.
module bus_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, clear, enable};
      assign expire = 1'b0;
    end else begin : g_on
      localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
      localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

      logic [CW-1:0] count_reg;

      // Down-counter: loaded with TIMEOUT-1 before entry, so it reads zero
      // in the last allowed BUSY cycle.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          count_reg <= '0;
        end else if (clear) begin
          count_reg <= LOAD;
        end else if (enable && (count_reg != '0)) begin
          count_reg <= count_reg - 1'b1;
        end
      end

      assign expire = enable && (count_reg == '0);
    end
  endgenerate

endmodule

// File: rtl/bus_router_n.sv
// 1-master to NUM_SLAVES-slave router for the req/ack bus.
// The slave is picked by m_addr[SEL_LSB +: SEL_W]; one transaction is
// outstanding at a time. Unmapped selects and slaves that stay silent for
// TIMEOUT BUSY cycles complete with m_err and ERR_RDATA.
// Ports:
//   clk, rst                       : clock, asynchronous active-low reset
//   m_req/m_cmd/m_addr/m_wdata     : master request (cmd 1 = write)
//   m_ack/m_rdata/m_err            : master completion strobe, data, error
//   s_req                          : one-hot registered slave request
//   s_cmd/s_addr/s_wdata           : latched request broadcast to slaves
//   s_ack/s_rdata                  : per-slave ack, flattened read data
//   busy                           : transaction in progress (BUSY or ERR)
//   err_cnt                        : saturating error completion count
module bus_router_n
  import bus_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SEL_LSB = 28,
  parameter int TIMEOUT = 16,
  parameter logic [DW-1:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     m_req,
  input  logic                     m_cmd,
  input  logic [AW-1:0]            m_addr,
  input  logic [DW-1:0]            m_wdata,
  output logic                     m_ack,
  output logic [DW-1:0]            m_rdata,
  output logic                     m_err,
  output logic [NUM_SLAVES-1:0]    s_req,
  output logic                     s_cmd,
  output logic [AW-1:0]            s_addr,
  output logic [DW-1:0]            s_wdata,
  input  logic [NUM_SLAVES-1:0]    s_ack,
  input  logic [NUM_SLAVES*DW-1:0] s_rdata,
  output logic                     busy,
  output logic [7:0]               err_cnt
);

  localparam int SEL_W = sel_width(NUM_SLAVES);
  // One extra bit so NUM_SLAVES = 2**SEL_W is representable.
  localparam logic [SEL_W:0] SLAVE_LIMIT = (SEL_W + 1)'(NUM_SLAVES);

  bus_rt_state_t state_reg, state_next;

  logic                  cmd_reg;
  logic [AW-1:0]         addr_reg;
  logic [DW-1:0]         wdata_reg;
  logic [SEL_W-1:0]      sel_reg;
  logic [NUM_SLAVES-1:0] s_req_reg, s_req_next;
  logic [7:0]            err_cnt_reg;

  logic [SEL_W-1:0]      sel_in;
  logic                  sel_in_mapped;
  logic [NUM_SLAVES-1:0] sel_in_onehot;
  logic [DW-1:0]         slave_rdata [NUM_SLAVES];
  logic                  sel_ack;
  logic [DW-1:0]         sel_rdata;

  logic wd_clear;
  logic wd_enable;
  logic wd_expire;

  assign sel_in        = m_addr[SEL_LSB +: SEL_W];
  assign sel_in_mapped = ({1'b0, sel_in} < SLAVE_LIMIT);

  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
      assign slave_rdata[gi]   = s_rdata[gi*DW +: DW];
      assign sel_in_onehot[gi] = (sel_in == SEL_W'(gi));
    end
  endgenerate

  // Ack/rdata of the latched slave only; other slaves' acks never reach
  // the FSM. Written as a compare loop so sel values beyond NUM_SLAVES-1
  // never index past the slave arrays.
  always_comb begin
    sel_ack   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_reg == SEL_W'(i)) begin
        sel_ack   = s_ack[i];
        sel_rdata = slave_rdata[i];
      end
    end
  end

  assign wd_enable = (state_reg == BUSY);
  assign wd_clear  = (state_reg != BUSY);

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      s_req_reg   <= '0;
      cmd_reg     <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      sel_reg     <= '0;
      err_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      s_req_reg <= s_req_next;
      if ((state_reg == IDLE) && m_req) begin
        cmd_reg   <= m_cmd;
        addr_reg  <= m_addr;
        wdata_reg <= m_wdata;
        sel_reg   <= sel_in;
      end
      if ((state_reg == ERR) && (err_cnt_reg != 8'hFF)) begin
        err_cnt_reg <= err_cnt_reg + 1'b1;
      end
    end
  end

  // Completion outputs are combinational so a slave ack is forwarded to
  // the master in the same cycle. An ack in the watchdog expiry cycle is
  // tested first and therefore wins over the timeout.
  always_comb begin
    state_next = state_reg;
    m_ack      = 1'b0;
    m_err      = 1'b0;
    m_rdata    = '0;
    case (state_reg)
      IDLE: begin
        if (m_req) begin
          state_next = sel_in_mapped ? BUSY : ERR;
        end
      end
      BUSY: begin
        if (sel_ack) begin
          m_ack      = 1'b1;
          state_next = IDLE;
          if (cmd_reg == CMD_READ) begin
            m_rdata = sel_rdata;
          end
        end else if (wd_expire) begin
          state_next = ERR;
        end
      end
      ERR: begin
        m_ack      = 1'b1;
        m_err      = 1'b1;
        m_rdata    = ERR_RDATA;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Registered one-hot request: set on entry to BUSY, held while BUSY.
  always_comb begin
    s_req_next = '0;
    if ((state_reg == IDLE) && m_req && sel_in_mapped) begin
      s_req_next = sel_in_onehot;
    end else if ((state_reg == BUSY) && (state_next == BUSY)) begin
      s_req_next = s_req_reg;
    end
  end

  assign s_req   = s_req_reg;
  assign s_cmd   = cmd_reg;
  assign s_addr  = addr_reg;
  assign s_wdata = wdata_reg;
  assign busy    = (state_reg != IDLE);
  assign err_cnt = err_cnt_reg;

endmodule
